// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, PC_MUX
// select codes and reset defaults.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_RUN  = 2'b11;

  localparam logic [XLEN-1:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~32'h0000_0001;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_ERR
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
    return target & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage around PC_MUX: owns the PC, runs the req/gnt/rvalid handshake
// to instruction memory and hands one instruction at a time to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR = DEFAULT_BOOT_ADDR,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [XLEN-1:0] pc_mux_in,
  input  logic            branch_taken_in,
  input  logic            stall_in,
  output logic [XLEN-1:0] pc_o,
  output logic [1:0]      pc_src_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_valid_o,
  output logic            fetch_misaligned_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misaligned_q, misaligned_d;
  logic            redirect;
  logic [XLEN-1:0] target;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_BOOT;
      pc_q          <= BOOT_ADDR;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= BOOT_ADDR;
      valid_q       <= 1'b0;
      pending_q     <= 1'b0;
      redirect_pc_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      valid_q       <= valid_d;
      pending_q     <= pending_d;
      redirect_pc_q <= redirect_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    valid_d       = valid_q & stall_in;
    pending_d     = pending_q;
    redirect_pc_d = redirect_pc_q;
    misaligned_d  = misaligned_q;
    redirect      = 1'b0;
    target        = pc_mux_in;

    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (branch_taken_in) begin
          redirect_pc_d = pc_mux_in;
          pending_d     = 1'b1;
          valid_d       = 1'b0;
        end
        if (imem_gnt_in) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid_in) begin
          // A response that raced a redirect belongs to the old path: drop it.
          if (pending_q || branch_taken_in) begin
            redirect  = 1'b1;
            target    = pending_q ? redirect_pc_q : pc_mux_in;
            pending_d = 1'b0;
            valid_d   = 1'b0;
            state_d   = ST_REQ;
          end else begin
            instr_d    = imem_rdata_in;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = align_pc(pc_mux_in);
            state_d    = stall_in ? ST_HOLD : ST_REQ;
          end
        end else if (branch_taken_in) begin
          redirect_pc_d = pc_mux_in;
          pending_d     = 1'b1;
          valid_d       = 1'b0;
        end
      end
      ST_HOLD: begin
        if (branch_taken_in) begin
          redirect = 1'b1;
          valid_d  = 1'b0;
          state_d  = ST_REQ;
        end else if (!stall_in) begin
          state_d = ST_REQ;
        end
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_BOOT;
    endcase

    // A redirect with bit 1 set cannot be a legal fetch address; stop fetching.
    if (redirect) begin
      pc_d = align_pc(target);
      if (target[1]) begin
        misaligned_d = 1'b1;
        valid_d      = 1'b0;
        state_d      = ST_ERR;
      end
    end
  end

  assign pc_o               = pc_q;
  assign imem_addr_o        = pc_q;
  assign imem_req_o         = (state_q == ST_REQ);
  assign pc_src_o           = (state_q == ST_BOOT) ? PC_SRC_BOOT : PC_SRC_RUN;
  assign instr_o            = valid_q ? instr_q : NOP_INSTR;
  assign instr_pc_o         = instr_pc_q;
  assign instr_valid_o      = valid_q;
  assign fetch_misaligned_o = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a flag-based behavioural
// model, plus directed sequences with hand-derived literal expectations.
module tb_instr_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] pc_mux_in;
  logic        branch_taken_in;
  logic        stall_in;
  logic [31:0] pc_o;
  logic [1:0]  pc_src_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        fetch_misaligned_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, kept as independent flags rather than an FSM code.
  logic [31:0] m_pc, m_instr, m_ipc, m_rpc;
  bit          m_valid, m_pend, m_mis, m_boot, m_err, m_inflight, m_hold;

  always #5 clk_in = ~clk_in;

  instr_fetch_unit dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .pc_mux_in(pc_mux_in),
    .branch_taken_in(branch_taken_in),
    .stall_in(stall_in),
    .pc_o(pc_o),
    .pc_src_o(pc_src_o),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_gnt_in(imem_gnt_in),
    .imem_rvalid_in(imem_rvalid_in),
    .imem_rdata_in(imem_rdata_in),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o),
    .fetch_misaligned_o(fetch_misaligned_o)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h00A0_0093;
    if (addr == 32'h4) return 32'h0010_0113;
    return (addr << 7) ^ 32'h0000_5013;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    bit requesting;
    requesting = !m_boot && !m_err && !m_inflight && !m_hold;
    cmp("pc_o", pc_o, m_pc);
    cmp("imem_addr_o", imem_addr_o, m_pc);
    cmp("imem_req_o", 32'(imem_req_o), 32'(requesting));
    cmp("pc_src_o", 32'(pc_src_o), m_boot ? 32'h0 : 32'h3);
    cmp("instr_valid_o", 32'(instr_valid_o), 32'(m_valid));
    cmp("instr_o", instr_o, m_valid ? m_instr : 32'h0000_0013);
    cmp("instr_pc_o", instr_pc_o, m_ipc);
    cmp("fetch_misaligned_o", 32'(fetch_misaligned_o), 32'(m_mis));
  endtask

  task automatic modelReset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_rpc = 32'h0;
    m_valid = 0; m_pend = 0; m_mis = 0; m_boot = 1; m_err = 0;
    m_inflight = 0; m_hold = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit requesting, load, valid_n;
    logic [31:0] t;
    requesting = !m_boot && !m_err && !m_inflight && !m_hold;
    load = 0;
    t = 32'h0;
    valid_n = m_valid && stall_in;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_err) begin
      load = 0;
    end else if (m_hold) begin
      if (branch_taken_in) begin
        load = 1; t = pc_mux_in; m_hold = 0;
      end else if (!stall_in) begin
        m_hold = 0;
      end
    end else if (m_inflight && imem_rvalid_in) begin
      m_inflight = 0;
      if (m_pend || branch_taken_in) begin
        load = 1;
        t = m_pend ? m_rpc : pc_mux_in;
        m_pend = 0;
      end else begin
        m_instr = imem_rdata_in;
        m_ipc = m_pc;
        valid_n = 1;
        m_pc = pc_mux_in & ~32'h1;
        m_hold = stall_in;
      end
    end else begin
      if (branch_taken_in) begin
        m_rpc = pc_mux_in; m_pend = 1; valid_n = 0;
      end
      if (requesting && imem_gnt_in) m_inflight = 1;
    end
    if (load) begin
      valid_n = 0;
      m_pc = t & ~32'h1;
      if (t[1]) begin
        m_mis = 1; m_err = 1;
      end
    end
    m_valid = valid_n;
  endtask

  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
  task automatic applyStimulus(input bit br, input bit stall, input bit gnt, input bit rvalid,
                               input logic [31:0] tgt);
    branch_taken_in = br;
    stall_in        = stall;
    imem_gnt_in     = gnt;
    imem_rvalid_in  = rvalid;
    pc_mux_in       = br ? tgt : m_pc + 32'd4;
    imem_rdata_in   = imem_word(m_pc);
    @(posedge clk_in);
    modelStep();
    @(negedge clk_in);
  endtask

  task automatic step(input bit br, input bit stall, input bit gnt, input bit rvalid,
                      input logic [31:0] tgt);
    checkOutput();
    applyStimulus(br, stall, gnt, rvalid, tgt);
  endtask

  // Asynchronous reset in the low clock phase, with stray responses during reset.
  task automatic doReset();
    #2 rst_in = 1'b1;
    modelReset();
    #1 checkOutput();
    imem_rvalid_in = 1'b1;
    imem_gnt_in    = 1'b1;
    imem_rdata_in  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput();
    rst_in = 1'b0;
  endtask

  initial begin
    bit br, stall, gnt, rvalid;
    logic [31:0] tgt;
    int r;
    rst_in = 1'b0; branch_taken_in = 1'b0; stall_in = 1'b0; imem_gnt_in = 1'b0;
    imem_rvalid_in = 1'b0; imem_rdata_in = 32'h0; pc_mux_in = 32'h0;
    modelReset();
    @(negedge clk_in);
    doReset();

    // Boot, then two zero-wait fetches at 0x0 and 0x4.
    cmp("boot pc_src", 32'(pc_src_o), 32'h0);
    step(0, 0, 1, 0, 0);
    cmp("run pc_src", 32'(pc_src_o), 32'h3);
    cmp("first req addr", imem_addr_o, 32'h0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    cmp("instr0 pc", instr_pc_o, 32'h0);
    cmp("instr0 word", instr_o, 32'h00A0_0093);
    cmp("second req addr", imem_addr_o, 32'h4);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    cmp("instr1 pc", instr_pc_o, 32'h4);
    cmp("instr1 word", instr_o, 32'h0010_0113);
    cmp("third req addr", imem_addr_o, 32'h8);

    // Grant withheld for three cycles, then a stalled capture held five cycles.
    repeat (3) step(0, 0, 0, 0, 0);
    cmp("no-gnt req", 32'(imem_req_o), 32'h1);
    cmp("no-gnt addr", imem_addr_o, 32'h8);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    repeat (5) step(0, 1, 1, 0, 0);
    cmp("hold req", 32'(imem_req_o), 32'h0);
    cmp("hold instr pc", instr_pc_o, 32'h8);
    cmp("hold instr word", instr_o, 32'h0000_5413);
    cmp("hold valid", 32'(instr_valid_o), 32'h1);
    step(0, 0, 0, 0, 0);
    cmp("post-hold addr", imem_addr_o, 32'hC);

    // Branch while waiting on 0x10, then a branch coincident with rvalid.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 32'h40);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    cmp("flush valid", 32'(instr_valid_o), 32'h0);
    cmp("redirect addr", imem_addr_o, 32'h40);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 32'h80);
    cmp("flush2 valid", 32'(instr_valid_o), 32'h0);
    cmp("redirect2 addr", imem_addr_o, 32'h80);

    // Misaligned redirect target parks the unit in its error state.
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 32'h102);
    repeat (3) step(0, 0, 1, 1, 0);
    cmp("misaligned flag", 32'(fetch_misaligned_o), 32'h1);
    cmp("err req", 32'(imem_req_o), 32'h0);

    // Reset while a fetch is outstanding.
    doReset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    doReset();
    cmp("rst instr", instr_o, 32'h0000_0013);
    cmp("rst misaligned", 32'(fetch_misaligned_o), 32'h0);
    step(0, 0, 0, 1, 0);
    cmp("reboot addr", imem_addr_o, 32'h0);
    cmp("reboot req", 32'(imem_req_o), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ((m_err && ($urandom % 8) == 0) || ($urandom % 600) == 0) begin
        doReset();
      end
      br     = ($urandom % 12) == 0;
      stall  = ($urandom % 4) == 0;
      gnt    = ($urandom % 3) != 0;
      rvalid = m_inflight ? (($urandom % 2) == 0) : (($urandom % 8) == 0);
      tgt    = 32'($urandom_range(0, 1023)) << 2;
      r      = int'($urandom % 24);
      if (r == 0) tgt = tgt | 32'h2;
      else if (r == 1) tgt = tgt | 32'h1;
      step(br, stall, gnt, rvalid, tgt);
    end
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
